// File: rtl/cic_comb_int.sv
// cic_comb_int: N-stage comb section of a CIC interpolator.
// Runs at the low input rate, qualified by val_in. Each stage computes
// y[n] = x[n] - x[n-M] at full Wout precision. One register per stage gives
// an N-cycle latency from val_in to val_out.
module cic_comb_int #(
    parameter int unsigned Win  = 16,
    parameter int unsigned N    = 3,
    parameter int unsigned M    = 1,
    parameter int unsigned Wout = Win + N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   val_in,
    input  logic signed [Win-1:0]  data_in,
    output logic                   val_out,
    output logic signed [Wout-1:0] data_out
);

    // Elaboration-time parameter checks
    if (Wout < Win + N) begin : g_bad_wout
        $error("cic_comb_int: Wout must be at least Win+N");
    end
    if (N < 1 || N > 8) begin : g_bad_n
        $error("cic_comb_int: N must be in 1..8");
    end
    if (M < 1 || M > 2) begin : g_bad_m
        $error("cic_comb_int: M must be 1 or 2");
    end

    // Stage inputs and enables (stage 0 is fed from the port)
    logic signed [Wout-1:0] stage_x  [N];
    logic                   stage_en [N];

    // Stage output registers, delay lines and valid pipeline
    logic signed [Wout-1:0] d   [N];
    logic signed [Wout-1:0] dly [N][M];
    logic [N-1:0]           vld;

    // Route each stage's input: sign-extended sample for stage 0, previous stage otherwise
    always_comb begin
        stage_x[0]  = {{(Wout - Win){data_in[Win-1]}}, data_in};
        stage_en[0] = val_in;
        for (int unsigned k = 1; k < N; k++) begin
            stage_x[k]  = d[k-1];
            stage_en[k] = vld[k-1];
        end
    end

    // Comb stages: subtract delayed input and advance the delay line only on a valid input
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                d[k] <= '0;
                for (int unsigned j = 0; j < M; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                vld[k] <= stage_en[k];
                if (stage_en[k]) begin
                    d[k]      <= stage_x[k] - dly[k][M-1];
                    dly[k][0] <= stage_x[k];
                    for (int unsigned j = 1; j < M; j++) begin
                        dly[k][j] <= dly[k][j-1];
                    end
                end
            end
        end
    end

    assign val_out  = vld[N-1];
    assign data_out = d[N-1];

endmodule
